// File: rtl/kbd_scan_fifo.sv
// PS/2 set-2 byte decoder feeding a show-ahead key-word FIFO with level IRQ; KBD_REPEAT_FILTER_EN drops typematic repeats.
// Latency: accepted byte -> key word visible on key_word/key_valid one clk later; head is combinational from storage.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module kbd_scan_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [15:0]   key_word,
    output logic          key_valid,
    output logic          irq,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t        state;
    logic          prev_tick;
    logic          accept;
    logic          dec_vld;
    logic [15:0]   dec_dat;
    logic          push_vld;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          do_pop;
    logic          do_wr;
    logic          drop;

    // Rising edge of the receiver strobe, so a stretched tick counts once.
    assign accept = rx_done_tick & ~prev_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_tick <= 1'b0;
        end else begin
            prev_tick <= rx_done_tick;
        end
    end

    always_comb begin
        dec_vld = 1'b0;
        dec_dat = 16'h0000;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!(rx_data inside {8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) begin
                        dec_vld = 1'b1;
                        dec_dat = {8'h00, rx_data};
                    end
                end
                GOT_E0: begin
                    if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                        dec_vld = 1'b1;
                        dec_dat = {8'h40, rx_data};
                    end
                end
                GOT_F0: begin
                    if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                        dec_vld = 1'b1;
                        dec_dat = {8'h80, rx_data};
                    end
                end
                GOT_E0F0: begin
                    if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                        dec_vld = 1'b1;
                        dec_dat = {8'hC0, rx_data};
                    end
                end
                default: ;
            endcase
        end
    end

    // A prefix byte where a scancode is expected is a protocol error: resync to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0)      state <= GOT_E0;
                    else if (rx_data == 8'hF0) state <= GOT_F0;
                end
                GOT_E0: begin
                    if (rx_data == 8'hF0)      state <= GOT_E0F0;
                    else if (rx_data != 8'hE0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KBD_REPEAT_FILTER_EN
    logic [15:0] held_dat;
    logic        held_vld;

    assign push_vld = dec_vld && !(!dec_dat[15] && held_vld && held_dat == dec_dat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_vld <= 1'b0;
            held_dat <= 16'h0000;
        end else if (dec_vld) begin
            if (dec_dat[15]) begin
                held_vld <= 1'b0;
            end else begin
                held_vld <= 1'b1;
                held_dat <= dec_dat;
            end
        end
    end
`else
    assign push_vld = dec_vld;
`endif

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign do_pop = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr  = push_vld && (!full || do_pop);
    assign drop   = push_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= dec_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign key_word  = empty ? 16'h0000 : mem[rd_ptr];
    assign key_valid = !empty;
    assign irq       = !empty;
    assign count     = cnt;

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Scoreboard bench for kbd_scan_fifo: stimulus queues expected words, a monitor checks every pop.
module tb_kbd_scan_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_done_tick;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic          clr_ovf;
    logic [15:0]   key_word;
    logic          key_valid;
    logic          irq;
    logic [CW-1:0] count;
    logic          overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    kbd_scan_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .key_word     (key_word),
        .key_valid    (key_valid),
        .irq          (irq),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every cycle the CPU pops a non-empty FIFO, the head must match the scoreboard.
    always @(negedge clk) begin
        if (reset_n && rd_en && key_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_word: got %h expected no word", key_word);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_word !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_word: got %h expected %h", key_word, mon_exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (key_valid) pop_one();
        end
        check({name, "_empty"}, {31'd0, key_valid}, 32'd0);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd_en        = 1'b0;
        clr_ovf      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_word", {16'd0, key_word}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single make: visible one cycle after the tick.
        rx_data = 8'h1C; rx_done_tick = 1'b1; exp_q.push_back(16'h001C);
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        check("make_valid", {31'd0, key_valid}, 32'd1);
        check("make_word", {16'd0, key_word}, 32'h001C);
        check("make_count", {28'd0, count}, 32'd1);
        check("make_irq", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        pop_one();
        check("pop_valid", {31'd0, key_valid}, 32'd0);
        check("pop_word_zero", {16'd0, key_word}, 32'd0);
        check("pop_count", {28'd0, count}, 32'd0);
        pop_one();
        check("empty_pop_count", {28'd0, count}, 32'd0);

        // Prefix decoding.
        send(8'hF0); send(8'h1C); exp_q.push_back(16'h801C);
        send(8'hE0); send(8'h75); exp_q.push_back(16'h4075);
        send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(16'hC075);
        check("prefix_count", {28'd0, count}, 32'd3);
        check("prefix_head", {16'd0, key_word}, 32'h801C);
        drain("prefix");

        // Stretched tick accepted once; AA discarded.
        rx_data = 8'h2A; rx_done_tick = 1'b1; exp_q.push_back(16'h002A);
        repeat (5) @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
        check("held_tick_count", {28'd0, count}, 32'd1);
        send(8'hAA);
        check("aa_discard_count", {28'd0, count}, 32'd1);
        drain("held_tick");

        // Reset abandons a pending E0 prefix.
        send(8'hE0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(8'h1C); exp_q.push_back(16'h001C);
        check("rst_prefix_word", {16'd0, key_word}, 32'h001C);
        drain("rst_prefix");

        // Fill past DEPTH: ninth word is dropped.
        for (int i = 0; i < 9; i++) begin
            send(8'(8'h10 + i));
            if (i < DEPTH) exp_q.push_back({8'h00, 8'(8'h10 + i)});
        end
        check("full_count", {28'd0, count}, 32'd8);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        check("full_head", {16'd0, key_word}, 32'h0010);

        // Clear coinciding with a new drop keeps the flag.
        rx_data = 8'h21; rx_done_tick = 1'b1; clr_ovf = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0; clr_ovf = 1'b0;
        check("clr_drop_overflow", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("clr_overflow", {31'd0, overflow}, 32'd0);

        // Push and pop together while full.
        rx_data = 8'h20; rx_done_tick = 1'b1; rd_en = 1'b1; exp_q.push_back(16'h0020);
        @(posedge clk); #1;
        rx_done_tick = 1'b0; rd_en = 1'b0;
        check("full_pushpop_count", {28'd0, count}, 32'd8);
        check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
        check("full_pushpop_head", {16'd0, key_word}, 32'h0011);
        @(posedge clk); #1;
        drain("full");

        // Typematic repeat.
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
        exp_q.push_back(16'h001C); exp_q.push_back(16'h801C); exp_q.push_back(16'h001C);
        check("repeat_count", {28'd0, count}, 32'd3);
`else
        exp_q.push_back(16'h001C); exp_q.push_back(16'h001C); exp_q.push_back(16'h001C);
        exp_q.push_back(16'h801C); exp_q.push_back(16'h001C);
        check("repeat_count", {28'd0, count}, 32'd5);
`endif
        drain("repeat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_scan_fifo.md
Name: kbd_scan_fifo

Overview:
- Sits between the PS/2 byte receiver and the CPU keyboard port on the board.
- Decodes raw PS/2 set-2 byte streams (E0 extended prefix, F0 break prefix) into 16-bit key words.
- Buffers key words in a show-ahead FIFO and raises a level interrupt while data is pending.
- The CPU reads the head word at the keyboard I/O address and pops it with a one-cycle strobe.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- CW, 4, width of the count output; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- rx_done_tick  input  1  byte-complete strobe from the PS/2 receiver, synchronous to clk.
- rx_data  input  8  received byte; valid while rx_done_tick is high.
- rd_en  input  1  pop strobe from the CPU read decode; one pop per high cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- key_word  output  16  FIFO head entry.
- key_valid  output  1  FIFO non-empty.
- irq  output  1  interrupt request; equals key_valid.
- count  output  CW  number of entries held.
- overflow  output  1  sticky flag: a key word was dropped.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, decoder FSM in IDLE, stored previous tick level = 0. All outputs 0.
- Byte acceptance:
  - A byte is accepted on the rising edge of rx_done_tick: tick high now and low on the previous clk.
  - A tick held high for several cycles is accepted exactly once.
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions per accepted byte b:
  - IDLE: b=E0 -> GOT_E0; b=F0 -> GOT_F0; b in {AA, FA, EE, 00, FF} -> discard, stay in IDLE; otherwise push {1'b0,1'b0,6'b0,b} and stay in IDLE.
  - GOT_E0: b=F0 -> GOT_E0F0; b=E0 -> stay in GOT_E0; otherwise push {0,1,6'b0,b} -> IDLE.
  - GOT_F0: b=E0 or F0 -> discard -> IDLE (protocol error); otherwise push {1,0,6'b0,b} -> IDLE.
  - GOT_E0F0: b=E0 or F0 -> discard -> IDLE; otherwise push {1,1,6'b0,b} -> IDLE.
- Word format: bit15 = break, bit14 = extended, bits13:8 = 0, bits7:0 = scancode.
- Latency: a push caused by an acceptance in cycle N makes the word visible on key_word/key_valid after the clk edge ending cycle N (registered; visible in cycle N+1).
- FIFO read side:
  - Show-ahead: key_word presents the head combinationally from the storage array; it reads 16'h0000 when empty.
  - rd_en while empty is ignored; pointers and count are unchanged.
- Simultaneous events:
  - Push and pop in the same cycle, not full: count unchanged, head advances.
  - Push and pop in the same cycle when full: both occur and no overflow is flagged.
  - Push when full without pop: word dropped, overflow set to 1.
- Overflow flag:
  - overflow stays set until clr_ovf is high at a clk edge.
  - If clr_ovf and a new drop occur in the same cycle, overflow stays 1.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count ranges 0..DEPTH.
- Reset mid-sequence: a partially decoded prefix (E0 or F0 pending) is abandoned, and the next byte is decoded from IDLE.

Optional Feature:
- Macro: KBD_REPEAT_FILTER_EN.
- Defined:
  - The block holds the last pushed make word (17-bit with a valid bit, cleared on reset).
  - A make word identical to the held word, with no intervening break, is discarded, suppressing typematic repeat.
  - A break word clears the held valid bit.
  - A make with a different code replaces the held word.
- Undefined: every decoded make word is pushed; no extra registers exist.

Test Plan:
- Reset, then bytes 1C -> key_valid=1 one cycle after tick, key_word=16'h001C, count=1, irq=1. Then rd_en for 1 cycle -> key_valid=0, key_word=16'h0000.
- Bytes F0,1C -> one word 16'h801C; bytes E0,75 -> 16'h4075; bytes E0,F0,75 -> 16'hC075, in that FIFO order.
- Push 9 make words with DEPTH=8 and no reads -> count=8, overflow=1, first 8 words read back in order. Then clr_ovf -> overflow=0.
- With FIFO full, rx tick and rd_en in the same cycle -> count stays 8, overflow stays 0, new word appears last.
- rx_done_tick held high 5 cycles with byte 2A -> exactly one word 16'h002A. Byte AA in IDLE -> no push.
- With KBD_REPEAT_FILTER_EN: bytes 1C,1C,1C,F0,1C,1C -> words 001C, 801C, 001C only. Without the macro: six bytes yield five words (three 001C, 801C, 001C).
